decoder_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable and a built-in auto-scan mode. Direct mode decodes an external select, as the lab combinational decoders do, but with registered outputs. Scan mode steps the active output through 0..last at a programmable rate, for multiplexed digit/LED enables. Emits a registered index and a wrap pulse so downstream data muxes stay aligned.

---
 rtl/decoder_scan_if.sv | 27 ++
 rtl/decoder_scan.sv | 83 ++++++++
 tb/tb_decoder_scan.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_if.sv
// Bundles the decoder's control inputs and registered decode outputs.
// The block drives the slave side; the controller or testbench drives the master side.
interface decoder_scan_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 8
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;
  logic [DIV_W-1:0] div;
  logic [OUT_W-1:0] D;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel, last, div,
    input  D, idx, wrap
  );

  modport slave (
    input  en, mode, sel, last, div,
    output D, idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and a
// prescaled auto-scan mode that emits the active index and a wrap pulse.
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] D_OFF = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state;
  logic [DIV_W-1:0] pre;
  logic [SEL_W-1:0] cnt;
  logic [OUT_W-1:0] d_p0;
  logic [SEL_W-1:0] idx_p0;
  logic             wrap_p0;

  logic             step_wrap;
  logic [SEL_W-1:0] cnt_step;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  // >= compares let a lowered last/div take effect on the very next step
  // instead of running the counter up to its width limit.
  assign step_wrap = (cnt >= bus.last);
  assign cnt_step  = step_wrap ? '0 : cnt + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre     <= '0;
      cnt     <= '0;
      d_p0    <= D_OFF;
      idx_p0  <= '0;
      wrap_p0 <= 1'b0;
    end else begin
      wrap_p0 <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
        pre   <= '0;
        d_p0  <= D_OFF;
      end else if (!bus.mode) begin
        state  <= DIRECT;
        pre    <= '0;
        cnt    <= '0;
        d_p0   <= decode(bus.sel);
        idx_p0 <= bus.sel;
      end else begin
        state <= SCAN;
        if (state != SCAN) begin
          // Any entry into scan, including the first edge after reset, restarts at index 0.
          pre    <= '0;
          cnt    <= '0;
          d_p0   <= decode('0);
          idx_p0 <= '0;
        end else if (pre >= bus.div) begin
          pre     <= '0;
          cnt     <= cnt_step;
          d_p0    <= decode(cnt_step);
          idx_p0  <= cnt_step;
          wrap_p0 <= step_wrap;
        end else begin
          pre <= pre + DIV_W'(1);
        end
      end
    end
  end

  assign bus.D    = d_p0;
  assign bus.idx  = idx_p0;
  assign bus.wrap = wrap_p0;
endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: constant vector table, hand-written
// scan/mode/reset sequences, then randomized stimulus against a reference model.
module tb_decoder_scan;
  localparam int SEL_W = 3;
  localparam int DIV_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();
  decoder_scan_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus_n ();

  assign bus_n.en   = bus.en;
  assign bus_n.mode = bus.mode;
  assign bus_n.sel  = bus.sel;
  assign bus_n.last = bus.last;
  assign bus_n.div  = bus.div;

  decoder_scan #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  decoder_scan #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n));

  int checks   = 0;
  int failures = 0;

  // Reference model: scan position, dwell counter and whether the previous edge was in scan.
  bit m_scan, m_on, m_wrap;
  int m_pre, m_cnt, m_idx;

  task automatic model_reset();
    m_scan = 0; m_on = 0; m_wrap = 0; m_pre = 0; m_cnt = 0; m_idx = 0;
  endtask

  task automatic model_edge();
    int dv, lst;
    dv  = int'(bus.div);
    lst = int'(bus.last);
    m_wrap = 0;
    if (!bus.en) begin
      m_scan = 0; m_on = 0; m_pre = 0;
    end else if (!bus.mode) begin
      m_scan = 0; m_on = 1; m_idx = int'(bus.sel); m_pre = 0; m_cnt = 0;
    end else if (!m_scan) begin
      m_scan = 1; m_on = 1; m_cnt = 0; m_pre = 0; m_idx = 0;
    end else if (m_pre >= dv) begin
      m_pre = 0;
      if (m_cnt >= lst) begin
        m_cnt = 0; m_wrap = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_idx = m_cnt;
    end else begin
      m_pre = m_pre + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk(string name, logic [7:0] e_d, int e_idx, bit e_wrap);
    logic [7:0] e_dn;
    e_dn = ~e_d;
    cmp({name, " D"},    32'(bus.D),     32'(e_d));
    cmp({name, " D_al"}, 32'(bus_n.D),   32'(e_dn));
    cmp({name, " idx"},  32'(bus.idx),   32'(e_idx));
    cmp({name, " wrap"}, 32'(bus.wrap),  32'(e_wrap));
    cmp({name, " wrap_al"}, 32'(bus_n.wrap), 32'(e_wrap));
  endtask

  task automatic chk_model(string name);
    logic [7:0] e_d;
    e_d = m_on ? (8'h01 << m_idx) : 8'h00;
    chk(name, e_d, m_idx, m_wrap);
  endtask

  typedef struct {
    bit         en;
    bit         mode;
    logic [2:0] sel;
    logic [2:0] last;
    logic [7:0] div;
    logic [7:0] e_d;
    logic [2:0] e_idx;
    bit         e_wrap;
  } vec_t;

  function automatic vec_t mk(bit en, bit mode, int sel, int last, int div,
                              int e_d, int e_idx, bit e_wrap);
    vec_t v;
    v.en = en; v.mode = mode; v.sel = 3'(sel); v.last = 3'(last); v.div = 8'(div);
    v.e_d = 8'(e_d); v.e_idx = 3'(e_idx); v.e_wrap = e_wrap;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.last = 3'd7; bus.div = '0;
    model_reset();

    // Vector table: idle after reset, direct sweep, full-range scan with div=0.
    tbl.push_back(mk(0, 0, 0, 7, 0, 8'h00, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, i, 7, 0, 1 << i, i, 0));
    tbl.push_back(mk(1, 1, 0, 7, 0, 8'h01, 0, 0));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(1, 1, 0, 7, 0, 1 << i, i, 0));
    tbl.push_back(mk(1, 1, 0, 7, 0, 8'h01, 0, 1));
    tbl.push_back(mk(1, 1, 0, 7, 0, 8'h02, 1, 0));

    #1 rst_n = 1'b0;
    #10;
    chk("reset", 8'h00, 0, 0);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      bus.en = tbl[k].en; bus.mode = tbl[k].mode; bus.sel = tbl[k].sel;
      bus.last = tbl[k].last; bus.div = tbl[k].div;
      tick();
      chk($sformatf("tbl[%0d]", k), tbl[k].e_d, int'(tbl[k].e_idx), tbl[k].e_wrap);
    end

    // Scan div=2 last=3: each index dwells three clocks; idle keeps idx.
    bus.en = 1'b0;
    tick(); chk("idle_hold", 8'h00, 1, 0);
    bus.en = 1'b1; bus.mode = 1'b1; bus.div = 8'd2; bus.last = 3'd3;
    for (int s = 0; s < 4; s++)
      for (int h = 0; h < 3; h++) begin
        tick(); chk($sformatf("dwell0_s%0d_h%0d", s, h), 8'h01 << s, s, 0);
      end
    for (int s = 0; s < 2; s++)
      for (int h = 0; h < 3; h++) begin
        tick(); chk($sformatf("dwell1_s%0d_h%0d", s, h), 8'h01 << s, s, (s == 0 && h == 0));
      end
    tick(); chk("dwell1_s2_h0", 8'h04, 2, 0);
    bus.last = 3'd1;
    tick(); chk("last_low_h1", 8'h04, 2, 0);
    tick(); chk("last_low_h2", 8'h04, 2, 0);
    tick(); chk("last_low_wrap", 8'h01, 0, 1);
    tick(); chk("div_low_pre1", 8'h01, 0, 0);
    bus.div = 8'd0;
    tick(); chk("div_low_step", 8'h02, 1, 0);

    // Mode and enable switching mid-scan.
    bus.last = 3'd7;
    tick(); chk("sw_scan4", 8'h04, 2, 0);
    tick(); chk("sw_scan8", 8'h08, 3, 0);
    bus.mode = 1'b0; bus.sel = 3'd5;
    tick(); chk("sw_direct5", 8'h20, 5, 0);
    bus.mode = 1'b1;
    tick(); chk("sw_rescan", 8'h01, 0, 0);
    tick(); chk("sw_rescan2", 8'h02, 1, 0);
    bus.en = 1'b0;
    tick(); chk("sw_disable", 8'h00, 1, 0);
    bus.en = 1'b1;
    tick(); chk("sw_reenable", 8'h01, 0, 0);

    // Asynchronous reset between edges while D=8'h10.
    tick(); tick(); tick(); tick();
    chk("pre_async", 8'h10, 4, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async_clear", 8'h00, 0, 0);
    #1 rst_n = 1'b1;
    tick(); chk("post_reset_entry", 8'h01, 0, 0);
    tick(); chk("post_reset_step", 8'h02, 1, 0);

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 3000; n++) begin
      bus.en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 24) == 0) bus.mode = ~bus.mode;
      bus.sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) bus.last = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0)
        bus.div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_model("rand_async");
        #1 rst_n = 1'b1;
      end
      tick();
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
